// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame state encoding, the baud divisor and the parity helper.
// The receive side imports the same package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned MAX_BITS = 16;

    function automatic int unsigned clk_max(input int unsigned rate, input int unsigned baud);
        return rate / baud;
    endfunction

    // Words narrower than MAX_BITS are zero-extended, which leaves XOR parity unchanged.
    function automatic logic parity(input logic [MAX_BITS-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake between a word source and the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned N_BITS = 8
) ();

    logic [N_BITS-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/uart_baud_div.sv
// Free-running baud counter. tick_c marks the last cycle of each bit period.
// clr restarts the period so the first bit is a full period long.
module uart_baud_div #(
    parameter int unsigned COUNT_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CW = $clog2(COUNT_MAX) + 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT_MAX - 1);

    logic [CW-1:0] count;

    assign tick_c = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick_c) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and sends
// start, data LSB-first, optional parity and stop bits on a registered tx line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE   = 12000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned N_BITS     = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  src,
    output logic      tx,
    output logic      busy,
    output logic      done
);

    localparam int unsigned CLK_MAX = clk_max(CLK_RATE, BAUD_RATE);
    localparam int unsigned BW      = $clog2(N_BITS) + 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(N_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (CLK_MAX < 2) begin : g_clk_max_chk
        $error("uart_tx: CLK_RATE/BAUD_RATE must be at least 2");
    end
    if (N_BITS < 5 || N_BITS > MAX_BITS) begin : g_n_bits_chk
        $error("uart_tx: N_BITS must be in 5..16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e       state, state_nxt;
    logic [N_BITS-1:0] shreg, shreg_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic              par_q, par_nxt;
    logic              tx_nxt, busy_nxt, done_nxt;
    logic              accept_c;
    logic              tick_c;

    assign src.data_ready = (state == IDLE) && !rst;
    assign accept_c       = src.data_valid && src.data_ready;

    uart_baud_div #(
        .COUNT_MAX (CLK_MAX)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept_c),
        .tick_c (tick_c)
    );

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            par_q   <= par_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next state: every transition after START waits for a baud tick.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par_q;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt   = START;
                    shreg_nxt   = src.data_in;
                    bit_cnt_nxt = '0;
                    par_nxt     = parity(MAX_BITS'(src.data_in), 1'(PARITY_ODD));
                end
            end
            START: begin
                if (tick_c) state_nxt = DATA;
            end
            DATA: begin
                if (tick_c) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick_c) state_nxt = STOP;
            end
            STOP: begin
                if (tick_c) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so tx/busy/done line up with it.
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && (state_nxt == IDLE);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = par_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at CLK_MAX=4, a cycle-exact
// line model per frame plus a serial decoder feeding a scoreboard of accepted words.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned CM = 4;

    typedef struct packed {
        logic [1:0]  sel;
        logic [7:0]  data;
        logic        par;
        int unsigned f;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       vld;
    logic [1:0] sel;
    logic [3:0] tx_v, busy_v, done_v, rdy_v;
    logic       tx_m, busy_m, done_m, rdy_m;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sbq[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    uart_tx_if #(.N_BITS(8)) if_a ();
    uart_tx_if #(.N_BITS(8)) if_p ();
    uart_tx_if #(.N_BITS(8)) if_o ();
    uart_tx_if #(.N_BITS(8)) if_s ();

    assign if_a.data_in = din;
    assign if_p.data_in = din;
    assign if_o.data_in = din;
    assign if_s.data_in = din;
    assign if_a.data_valid = vld && (sel == 2'd0);
    assign if_p.data_valid = vld && (sel == 2'd1);
    assign if_o.data_valid = vld && (sel == 2'd2);
    assign if_s.data_valid = vld && (sel == 2'd3);
    assign rdy_v = {if_s.data_ready, if_o.data_ready, if_p.data_ready, if_a.data_ready};

    uart_tx #(.CLK_RATE(12), .BAUD_RATE(3)) dut_a (
        .clk(clk), .rst(rst), .src(if_a), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx #(.CLK_RATE(12), .BAUD_RATE(3), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .src(if_p), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx #(.CLK_RATE(12), .BAUD_RATE(3), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .src(if_o), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    uart_tx #(.CLK_RATE(12), .BAUD_RATE(3), .STOP_BITS(2)) dut_s (
        .clk(clk), .rst(rst), .src(if_s), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    assign tx_m   = tx_v[sel];
    assign busy_m = busy_v[sel];
    assign done_m = done_v[sel];
    assign rdy_m  = rdy_v[sel];

    function automatic logic cfg_par(input logic [1:0] s);
        return (s == 2'd1) || (s == 2'd2);
    endfunction

    function automatic logic cfg_odd(input logic [1:0] s);
        return s == 2'd2;
    endfunction

    function automatic int cfg_stop(input logic [1:0] s);
        return (s == 2'd3) ? 2 : 1;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait for ready, hand over one word, record it for the decoder.
    task automatic accept(input logic [7:0] d);
        int   w;
        exp_t e;
        w = 0;
        #1;
        while (rdy_m !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (rdy_m !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_wait: data_ready got %b, expected 1", rdy_m);
        end
        din = d;
        vld = 1'b1;
        @(posedge clk);
        e.data = d;
        e.par  = (^d) ^ cfg_odd(sel);
        sbq.push_back(e);
        #1 vld = 1'b0;
    endtask

    // Called just after the accepting edge; walks cycles 1..f+1 against the line model.
    task automatic check_frame(input logic [7:0] d, input logic exp_par, input int f,
                               input bit scramble);
        int   bad_tx, bad_busy, bad_done, first, idx;
        logic e;
        bad_tx = 0; bad_busy = 0; bad_done = 0; first = -1;
        for (int c = 1; c <= f; c++) begin
            @(negedge clk);
            idx = (c - 1) / CM;
            if (idx == 0)                      e = 1'b0;
            else if (idx <= 8)                 e = d[idx-1];
            else if (cfg_par(sel) && idx == 9) e = exp_par;
            else                               e = 1'b1;
            if (tx_m !== e) begin
                bad_tx++;
                if (first < 0) first = c;
            end
            if (busy_m !== 1'b1) bad_busy++;
            if (done_m !== 1'b0) bad_done++;
            if (scramble) begin
                din = 8'($urandom);
                vld = (c < f) ? 1'($urandom) : 1'b0;
            end
        end
        @(negedge clk);
        check_int($sformatf("tx_bits(sel %0d data %h first bad cycle %0d)", sel, d, first),
                  bad_tx, 0);
        check_int("busy_in_frame", bad_busy, 0);
        check_int("done_early", bad_done, 0);
        check_bit("done_at_end", done_m, 1'b1);
        check_bit("busy_at_end", busy_m, 1'b0);
        check_bit("ready_at_end", rdy_m, 1'b1);
    endtask

    // Serial decoder: samples the second cycle of every bit and pops the scoreboard.
    int         m_cnt, m_k, m_last;
    bit         m_act = 1'b0;
    bit         m_ok;
    logic [7:0] m_word;
    logic       m_par;
    exp_t       m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (tx_m === 1'b0) begin
                m_act = 1'b1;
                m_cnt = 0;
                m_ok  = 1'b1;
            end
        end else begin
            m_cnt++;
            if (m_cnt % CM == 1) begin
                m_k    = m_cnt / CM;
                m_last = 8 + int'(cfg_par(sel)) + cfg_stop(sel);
                if (m_k == 0) begin
                    if (tx_m !== 1'b0) m_ok = 1'b0;
                end else if (m_k <= 8) begin
                    m_word[m_k-1] = tx_m;
                end else if (cfg_par(sel) && m_k == 9) begin
                    m_par = tx_m;
                end else if (tx_m !== 1'b1) begin
                    m_ok = 1'b0;
                end
                if (m_k == m_last) begin
                    m_act = 1'b0;
                    n_vec++;
                    if (sbq.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: decoded %h, expected no frame", m_word);
                    end else begin
                        m_e = sbq.pop_front();
                        if (m_word !== m_e.data || !m_ok || (cfg_par(sel) && m_par !== m_e.par)) begin
                            n_err++;
                            $display("FAIL sb_word: got %h par %b framing_ok %0d, expected %h par %b framing_ok 1",
                                     m_word, m_par, m_ok, m_e.data, m_e.par);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no $finish by 500us, expected completion");
        $fatal(1);
    end

    initial begin
        int bad;
        vecs[0] = '{2'd0, 8'hA5, 1'b0, 40};
        vecs[1] = '{2'd0, 8'h00, 1'b0, 40};
        vecs[2] = '{2'd0, 8'hFF, 1'b0, 40};
        vecs[3] = '{2'd0, 8'h5A, 1'b0, 40};
        vecs[4] = '{2'd1, 8'h07, 1'b1, 44};
        vecs[5] = '{2'd2, 8'h07, 1'b0, 44};
        vecs[6] = '{2'd1, 8'h03, 1'b0, 44};
        vecs[7] = '{2'd2, 8'h80, 1'b0, 44};
        vecs[8] = '{2'd3, 8'h3C, 1'b0, 44};
        vecs[9] = '{2'd3, 8'h01, 1'b0, 44};

        rst = 1'b1; vld = 1'b0; din = 8'h00; sel = 2'd0;
        repeat (3) @(negedge clk);
        check_int("rst_tx_all", int'(tx_v), 15);
        check_int("rst_busy_all", int'(busy_v), 0);
        check_int("rst_done_all", int'(done_v), 0);
        check_int("rst_ready_all", int'(rdy_v), 0);
        rst = 1'b0;
        @(negedge clk);
        check_int("ready_after_rst", int'(rdy_v), 15);

        // Table of single frames across all four configurations.
        for (int i = 0; i < 10; i++) begin
            sel = vecs[i].sel;
            accept(vecs[i].data);
            check_frame(vecs[i].data, vecs[i].par, int'(vecs[i].f), 1'b0);
        end

        // Back-to-back with data_valid held: second start bit one cycle after done.
        sel = 2'd0;
        #1;
        din = 8'h00; vld = 1'b1;
        @(posedge clk);
        sbq.push_back('{8'h00, 1'b0});
        #1 din = 8'hFF;
        check_frame(8'h00, 1'b0, 40, 1'b0);
        @(posedge clk);
        sbq.push_back('{8'hFF, 1'b0});
        #1 vld = 1'b0;
        check_frame(8'hFF, 1'b0, 40, 1'b0);

        // Reset in the middle of a frame discards the word without a done pulse.
        accept(8'hC3);
        for (int c = 1; c <= 15; c++) @(negedge clk);
        check_bit("tx_before_rst", tx_m, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_bit("rst_mid_tx", tx_m, 1'b1);
        check_bit("rst_mid_busy", busy_m, 1'b0);
        check_bit("rst_mid_ready", rdy_m, 1'b0);
        rst = 1'b0;
        sbq.delete();
        bad = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            if (done_m !== 1'b0 || tx_m !== 1'b1) bad++;
        end
        check_int("quiet_after_rst", bad, 0);
        check_bit("ready_after_mid_rst", rdy_m, 1'b1);
        accept(8'h96);
        check_frame(8'h96, 1'b0, 40, 1'b0);

        // Reset coincident with a valid word: nothing starts.
        rst = 1'b1; din = 8'h55; vld = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (tx_m !== 1'b1 || busy_m !== 1'b0) bad++;
        end
        check_int("rst_beats_accept", bad, 0);

        // Inputs churning while busy must not disturb the latched word.
        sel = 2'd0;
        accept(8'h6B);
        check_frame(8'h6B, 1'b0, 40, 1'b1);
        sel = 2'd1;
        accept(8'hE1);
        check_frame(8'hE1, 1'b0, 44, 1'b1);

        repeat (4) @(negedge clk);
        check_int("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
